sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
// - Round-robin arbiter sharing one OBI slave port of the SRAM wrapper (data or instr port) among NUM_REQ OBI masters.
//   Typical masters: core LSU, debug module, DMA.
// - Forwards the winning request to the downstream port.
// - Tracks up to MAX_OUTSTANDING issued transactions in order and routes each response (rvalid/rdata) back to its issuer.
// - Sits between the crossbar/master side and sram_wrap; sram_wrap grants combinationally and returns rvalid 1 cycle later.
// PARAMETERS
// - NUM_REQ          2   number of upstream OBI masters (>=2)
// - MAX_OUTSTANDING  2   depth of the in-flight owner-ID FIFO (>=1)
// - ID_W  $clog2(NUM_REQ)  width of the requester index (derived)
// PORTS
// - clk_i        in   1            system clock
// - rst_ni       in   1            synchronous active-low reset
// - m_req_i      in   NUM_REQ      per-master OBI request
// - m_gnt_o      out  NUM_REQ      per-master grant (one-hot or zero)
// - m_addr_i     in   NUM_REQ*32   per-master address, master k at [32k+:32]
// - m_we_i       in   NUM_REQ      per-master write enable
// - m_be_i       in   NUM_REQ*4    per-master byte enables
// - m_wdata_i    in   NUM_REQ*32   per-master write data
// - m_rvalid_o   out  NUM_REQ      per-master response valid (one-hot or zero)
// - m_rdata_o    out  NUM_REQ*32   per-master read data (all lanes driven from s_rdata_i)
// - s_req_o      out  1            downstream request
// - s_gnt_i      in   1            downstream grant
// - s_addr_o     out  32           downstream address
// - s_we_o       out  1            downstream write enable
// - s_be_o       out  4            downstream byte enables
// - s_wdata_o    out  32           downstream write data
// - s_rvalid_i   in   1            downstream response valid
// - s_rdata_i    in   32           downstream read data
// - orphan_rsp_o out  1            sticky flag: s_rvalid_i arrived while no transaction was outstanding
// BEHAVIOUR
// - Reset state: rr_ptr = NUM_REQ-1, so master 0 has top priority first; FIFO empty, count 0; orphan_rsp_o 0.
//   All outputs are combinational from this state and read 0 while m_req_i = 0.
// - Arbitration (combinational, same cycle):
//   - Winner = first k with m_req_i[k], scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//   - s_req_o = |m_req_i && can_issue.
//   - s_addr_o/we/be/wdata = winner's fields; these fields are 0 when no request is present.
// - Grant: m_gnt_o[winner] = s_gnt_i && s_req_o; all other grant bits are 0.
//   The handshake is accepted when s_req_o && s_gnt_i.
// - On handshake: rr_ptr <= winner, and winner ID is pushed to the FIFO. rr_ptr is unchanged when there is no handshake.
// - A requester keeps its slot while it holds req without a grant. The pointer moves only on acceptance, which guarantees fairness.
// - can_issue = (count < MAX_OUTSTANDING) || s_rvalid_i. A pop and a push in the same cycle are legal when the FIFO is full.
//   This creates a combinational path s_rvalid_i -> s_req_o, which is acceptable because sram_wrap registers rvalid.
// - Response routing: when s_rvalid_i && count>0, m_rvalid_o[fifo_head] = 1 and the head is popped.
//   m_rdata_o lanes always carry s_rdata_i; masters qualify the data with rvalid.
// - Count update:
//   - push only: count+1; pop only: count-1; both: count unchanged (head advances, tail advances).
//   - Pointers wrap modulo MAX_OUTSTANDING.
// - Orphan response: s_rvalid_i with count==0 drives no m_rvalid_o and sets orphan_rsp_o; only reset clears it.
// - Reset mid-operation flushes the FIFO. A response arriving in the first cycle after reset is an orphan and is flagged, not delivered.
// - Writes also produce rvalid (OBI) and are tracked identically.
// STRUCTURE
// - Shared package sram_arb_pkg holds:
//   - function rr_pick(req, ptr) returning the winner index;
//   - typedef obi_req_t {addr[31:0], we, be[3:0], wdata[31:0]}.
// - Sub-module sram_arb_id_fifo: a synchronous FIFO, width ID_W and depth MAX_OUTSTANDING.
//   It provides push/pop/full/empty/head plus a simultaneous push+pop when full.
// - The top holds the rr_ptr register, mux and demux, and the orphan flag.
// TESTING
// - Reset, then m_req_i=2'b11 held with s_gnt_i=1:
//   - cycle 0 grants m0, cycle 1 grants m1, cycle 2 grants m0 (alternates);
//   - each m_rvalid_o pulse arrives 1 cycle after its grant, to the same master.
// - m_req_i=2'b01 with s_gnt_i=0 for 3 cycles:
//   - m_gnt_o=0 and rr_ptr is unchanged;
//   - when s_gnt_i rises, m0 is granted and its addr 0x8000_0010 appears on s_addr_o.
// - MAX_OUTSTANDING=1, responder with 3-cycle latency:
//   - second request is stalled (s_req_o=0) until s_rvalid_i;
//   - in that cycle both the pop and the push occur, and count stays 1.
// - m1 reads 0x8000_0804 while m0 writes 0x8000_0004 (be=4'b0011):
//   - downstream sees the fields of the correct winner;
//   - rdata 0xDEADBEEF is flagged only on m_rvalid_o[1].
// - Pulse s_rvalid_i with nothing outstanding -> orphan_rsp_o=1 and no m_rvalid_o; the flag stays 1 until rst_ni=0.
// - Assert rst_ni=0 with 2 transactions in flight -> count=0, rr_ptr=NUM_REQ-1; a subsequent stray rvalid sets orphan_rsp_o.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick function used by the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  // Returns the first requester after ptr (wrapping modulo n); 0 when nobody requests.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if ((i <= n) && !found && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions issued downstream and not yet answered.
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one OBI SRAM port among NUM_REQ masters, routing responses in order.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    m_req_i,
  output logic [NUM_REQ-1:0]    m_gnt_o,
  input  logic [NUM_REQ*32-1:0] m_addr_i,
  input  logic [NUM_REQ-1:0]    m_we_i,
  input  logic [NUM_REQ*4-1:0]  m_be_i,
  input  logic [NUM_REQ*32-1:0] m_wdata_i,
  output logic [NUM_REQ-1:0]    m_rvalid_o,
  output logic [NUM_REQ*32-1:0] m_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic [31:0]           s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  output logic                  orphan_rsp_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               orphan_q, orphan_d;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    head_id;
  logic [MAX_REQ-1:0] req_ext;
  logic               any_req, can_issue, handshake, pop;
  logic               fifo_full, fifo_empty;
  obi_req_t           sel;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = m_req_i;
    winner                 = ID_W'(rr_pick(req_ext, 32'(rr_ptr_q), NUM_REQ));
  end

  // A full FIFO may still issue when a response frees a slot this very cycle.
  assign any_req   = |m_req_i;
  assign can_issue = !fifo_full || s_rvalid_i;
  assign s_req_o   = any_req && can_issue;
  assign handshake = s_req_o && s_gnt_i;
  assign pop       = s_rvalid_i && !fifo_empty;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (any_req && (winner == ID_W'(k))) begin
        sel.addr  = m_addr_i[32*k +: 32];
        sel.we    = m_we_i[k];
        sel.be    = m_be_i[4*k +: 4];
        sel.wdata = m_wdata_i[32*k +: 32];
      end
    end
  end

  assign s_addr_o  = sel.addr;
  assign s_we_o    = sel.we;
  assign s_be_o    = sel.be;
  assign s_wdata_o = sel.wdata;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      m_gnt_o[k]    = handshake && (winner == ID_W'(k));
      m_rvalid_o[k] = pop && (head_id == ID_W'(k));
    end
  end

  assign m_rdata_o    = {NUM_REQ{s_rdata_i}};
  assign orphan_rsp_o = orphan_q;

  always_comb begin
    rr_ptr_d = handshake ? winner : rr_ptr_q;
    orphan_d = orphan_q || (s_rvalid_i && fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  sram_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, directed corner sequences and a randomized reference model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_req = '0;
  logic [63:0] m_addr = '0;
  logic [1:0]  m_we = '0;
  logic [7:0]  m_be = '0;
  logic [63:0] m_wdata = '0;
  logic        s_gnt = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  m_gnt, m_rvalid;
  logic [63:0] m_rdata;
  logic        s_req, s_we, orphan;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  logic [1:0]  d1_req = '0;
  logic        d1_gnt = 1'b0;
  logic        d1_rv = 1'b0;
  logic [1:0]  d1_m_gnt, d1_m_rvalid;
  logic [63:0] d1_m_rdata;
  logic        d1_s_req, d1_s_we, d1_orphan;
  logic [31:0] d1_s_addr, d1_s_wdata;
  logic [3:0]  d1_s_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .orphan_rsp_o(orphan)
  );

  sram_port_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(d1_req), .m_gnt_o(d1_m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(d1_m_rvalid), .m_rdata_o(d1_m_rdata),
    .s_req_o(d1_s_req), .s_gnt_i(d1_gnt), .s_addr_o(d1_s_addr), .s_we_o(d1_s_we),
    .s_be_o(d1_s_be), .s_wdata_o(d1_s_wdata), .s_rvalid_i(d1_rv), .s_rdata_i(s_rdata),
    .orphan_rsp_o(d1_orphan)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    d1_req = '0; d1_gnt = 1'b0; d1_rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [1:0] req, input logic gnt, input logic rv);
    @(negedge clk);
    m_req = req; s_gnt = gnt; s_rvalid = rv;
    #1;
  endtask

  task automatic set_in1(input logic [1:0] req, input logic gnt, input logic rv);
    @(negedge clk);
    d1_req = req; d1_gnt = gnt; d1_rv = rv;
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    logic       exp_sreq;
  } vec_t;

  vec_t tbl[5];

  // Reference model state: owner queue in issue order, last-served index, sticky orphan.
  int mrr;
  int mq[$];
  bit morph;

  initial begin
    int w;
    bit can, esreq, hs, pop;
    logic [1:0] egnt, erv;
    logic [31:0] eaddr, ewdata;
    logic ewe;
    logic [3:0] ebe;

    tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1};
    tbl[1] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1};
    tbl[2] = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1};
    tbl[3] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0};
    tbl[4] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

    m_addr = {32'h8000_0020, 32'h8000_0010};
    m_be   = 8'hFF;

    // Reset state
    do_reset();
    set_in(2'b00, 1'b0, 1'b0);
    chk("reset_gnt", 64'(m_gnt), 64'h0);
    chk("reset_rvalid", 64'(m_rvalid), 64'h0);
    chk("reset_sreq", 64'(s_req), 64'h0);
    chk("reset_fields", {s_addr, s_we, s_be, s_wdata[26:0]}, 64'h0);
    chk("reset_orphan", 64'(orphan), 64'h0);

    // Held request without grant keeps priority
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, 1'b0, 1'b0);
      chk("stall_gnt", 64'(m_gnt), 64'h0);
      chk("stall_sreq", 64'(s_req), 64'h1);
    end
    set_in(2'b11, 1'b1, 1'b0);
    chk("stall_release_gnt", 64'(m_gnt), 64'h1);
    chk("stall_release_addr", 64'(s_addr), 64'h8000_0010);
    set_in(2'b00, 1'b0, 1'b1);
    chk("stall_rsp", 64'(m_rvalid), 64'h1);

    // Alternating grants from the vector table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(tbl[i].req, tbl[i].gnt, tbl[i].rv);
      chk($sformatf("tbl%0d_gnt", i), 64'(m_gnt), 64'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_rvalid", i), 64'(m_rvalid), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_sreq", i), 64'(s_req), 64'(tbl[i].exp_sreq));
    end

    // Mixed read/write: m0 was served last, so m1 wins first
    m_addr  = {32'h8000_0804, 32'h8000_0004};
    m_we    = 2'b01;
    m_be    = {4'b1111, 4'b0011};
    m_wdata = {32'h0, 32'hA5A5_0001};
    set_in(2'b11, 1'b1, 1'b0);
    chk("mix_gnt1", 64'(m_gnt), 64'h2);
    chk("mix_addr1", 64'(s_addr), 64'h8000_0804);
    chk("mix_we1", 64'(s_we), 64'h0);
    s_rdata = 32'hDEAD_BEEF;
    set_in(2'b01, 1'b1, 1'b1);
    chk("mix_rvalid1", 64'(m_rvalid), 64'h2);
    chk("mix_rdata1", 64'(m_rdata[63:32]), 64'hDEAD_BEEF);
    chk("mix_gnt0", 64'(m_gnt), 64'h1);
    chk("mix_fields0", {s_addr, s_we, s_be, s_wdata[26:0]}, {32'h8000_0004, 1'b1, 4'b0011, 27'(32'hA5A5_0001)});
    s_rdata = 32'h0000_1111;
    set_in(2'b00, 1'b0, 1'b1);
    chk("mix_rvalid0", 64'(m_rvalid), 64'h1);

    // Orphan response
    set_in(2'b00, 1'b0, 1'b0);
    chk("orphan_before", 64'(orphan), 64'h0);
    set_in(2'b00, 1'b0, 1'b1);
    chk("orphan_no_rvalid", 64'(m_rvalid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(2'b00, 1'b0, 1'b0);
      chk("orphan_sticky", 64'(orphan), 64'h1);
    end

    // Reset with two transactions in flight
    set_in(2'b01, 1'b1, 1'b0);
    chk("fill_gnt_a", 64'(m_gnt), 64'h1);
    set_in(2'b01, 1'b1, 1'b0);
    chk("fill_gnt_b", 64'(m_gnt), 64'h1);
    set_in(2'b01, 1'b1, 1'b0);
    chk("full_stall_sreq", 64'(s_req), 64'h0);
    chk("full_stall_gnt", 64'(m_gnt), 64'h0);
    set_in(2'b11, 1'b1, 1'b1);
    chk("full_poppush_gnt", 64'(m_gnt), 64'h2);
    chk("full_poppush_rv", 64'(m_rvalid), 64'h1);
    do_reset();
    set_in(2'b00, 1'b0, 1'b1);
    chk("rst_flush_rvalid", 64'(m_rvalid), 64'h0);
    chk("rst_orphan_clear", 64'(orphan), 64'h0);
    set_in(2'b11, 1'b1, 1'b0);
    chk("rst_orphan_set", 64'(orphan), 64'h1);
    chk("rst_ptr_gnt", 64'(m_gnt), 64'h1);
    set_in(2'b00, 1'b0, 1'b1);
    chk("rst_after_rsp", 64'(m_rvalid), 64'h1);

    // Single-slot instance with a 3-cycle responder
    do_reset();
    set_in1(2'b01, 1'b1, 1'b0);
    chk("d1_first_gnt", 64'(d1_m_gnt), 64'h1);
    for (int i = 0; i < 2; i++) begin
      set_in1(2'b01, 1'b1, 1'b0);
      chk("d1_stall_sreq", 64'(d1_s_req), 64'h0);
    end
    set_in1(2'b01, 1'b1, 1'b1);
    chk("d1_poppush_sreq", 64'(d1_s_req), 64'h1);
    chk("d1_poppush_gnt", 64'(d1_m_gnt), 64'h1);
    chk("d1_poppush_rv", 64'(d1_m_rvalid), 64'h1);
    set_in1(2'b01, 1'b1, 1'b0);
    chk("d1_count_still1", 64'(d1_s_req), 64'h0);
    set_in1(2'b00, 1'b0, 1'b1);
    chk("d1_last_rv", 64'(d1_m_rvalid), 64'h1);
    set_in1(2'b01, 1'b0, 1'b0);
    chk("d1_empty_sreq", 64'(d1_s_req), 64'h1);
    chk("d1_orphan", 64'(d1_orphan), 64'h0);

    // Randomized traffic against the reference model
    do_reset();
    mrr = 1; mq.delete(); morph = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      m_req    = 2'($urandom_range(0, 3));
      s_gnt    = ($urandom_range(0, 3) != 0);
      s_rvalid = ($urandom_range(0, 2) != 0);
      m_addr   = {$urandom, $urandom};
      m_we     = 2'($urandom_range(0, 3));
      m_be     = 8'($urandom_range(0, 255));
      m_wdata  = {$urandom, $urandom};
      s_rdata  = $urandom;
      #1;
      w = -1;
      for (int i = 1; i <= 2; i++) begin
        if (w < 0 && m_req[(mrr + i) % 2]) w = (mrr + i) % 2;
      end
      can   = (mq.size() < 2) || s_rvalid;
      esreq = (w >= 0) && can;
      hs    = esreq && s_gnt;
      pop   = s_rvalid && (mq.size() > 0);
      egnt  = '0;
      erv   = '0;
      if (hs) egnt[w] = 1'b1;
      if (pop) erv[mq[0]] = 1'b1;
      eaddr = '0; ewe = 1'b0; ebe = '0; ewdata = '0;
      if (w >= 0) begin
        eaddr  = m_addr[32*w +: 32];
        ewe    = m_we[w];
        ebe    = m_be[4*w +: 4];
        ewdata = m_wdata[32*w +: 32];
      end
      chk("rnd_ctrl", {58'h0, m_gnt, m_rvalid, s_req, orphan}, {58'h0, egnt, erv, esreq, morph});
      chk("rnd_fields", {s_addr, s_we, s_be, s_wdata[26:0]}, {eaddr, ewe, ebe, ewdata[26:0]});
      chk("rnd_rdata", m_rdata, {s_rdata, s_rdata});
      if (s_rvalid && mq.size() == 0) morph = 1;
      if (pop) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(w);
        mrr = w;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
